// File: rtl/mem_bus_arbiter.sv
// Two-master / one-slave physical memory bus arbiter.
// Master 0 is the instruction-side MMU, master 1 the data-side MMU.
// Ownership is granted round-robin and held while an access is outstanding.
// An access the slave never completes is aborted after TIMEOUT cycles.
//
// Handshake: a strobe (mN_we / mN_rd) is one cycle wide and is only passed to
// the slave while that master owns the bus, s_gnt=1 and s_hrd=0. A passed
// strobe opens an access, which is closed by s_ready (or by a timeout abort).
// The owner sees s_ready/s_spo directly; the non-owner sees ready=0, spo=0.
`timescale 1ns/1ps
module mem_bus_arbiter #(
    parameter int TIMEOUT = 1024,
    parameter int TCW     = $clog2(TIMEOUT) + 1
) (
    input  logic        clk,
    input  logic        rst,
    // master 0 (instruction MMU)
    input  logic        m0_req,
    output logic        m0_gnt,
    output logic        m0_hrd,
    input  logic [31:0] m0_a,
    input  logic [31:0] m0_d,
    input  logic        m0_we,
    input  logic        m0_rd,
    output logic [31:0] m0_spo,
    output logic        m0_ready,
    // master 1 (data MMU)
    input  logic        m1_req,
    output logic        m1_gnt,
    output logic        m1_hrd,
    input  logic [31:0] m1_a,
    input  logic [31:0] m1_d,
    input  logic        m1_we,
    input  logic        m1_rd,
    output logic [31:0] m1_spo,
    output logic        m1_ready,
    // slave side
    output logic        s_req,
    input  logic        s_gnt,
    input  logic        s_hrd,
    output logic [31:0] s_a,
    output logic [31:0] s_d,
    output logic        s_we,
    output logic        s_rd,
    input  logic [31:0] s_spo,
    input  logic        s_ready,
    // abort reporting
    output logic        err_timeout,
    output logic        err_master,
    // current arbiter state, for observation
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    // Counter value in the cycle whose increment reaches TIMEOUT-1 (abort cycle).
    localparam logic [TCW-1:0] CNT_HIT = TCW'(TIMEOUT - 2);
    localparam logic [TCW-1:0] CNT_MAX = TCW'(TIMEOUT - 1);

    state_t         state, state_nxt;
    logic           last, last_nxt;        // master that owned the bus most recently
    logic           pending, pending_nxt;  // an access is waiting for s_ready
    logic [TCW-1:0] cnt, cnt_nxt;          // cycles spent waiting on the slave

    logic           active, sel, strobe, timeout_hit;
    logic           o_req, o_we, o_rd, o_rdy;
    logic [31:0]    o_a, o_d, o_spo;

    assign dbg_state = state;

    // State, last-owner, pending flag and timeout counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last    <= 1'b1;
            pending <= 1'b0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            last    <= last_nxt;
            pending <= pending_nxt;
            cnt     <= cnt_nxt;
        end
    end

    // Arbitration, owner muxing, access tracking and per-master output routing.
    always_comb begin
        state_nxt   = state;
        last_nxt    = last;
        pending_nxt = pending;
        cnt_nxt     = cnt;
        active      = 1'b0;
        sel         = 1'b0;
        strobe      = 1'b0;
        timeout_hit = 1'b0;
        o_req       = 1'b0;
        o_we        = 1'b0;
        o_rd        = 1'b0;
        o_a         = '0;
        o_d         = '0;
        o_rdy       = 1'b0;
        o_spo       = '0;
        m0_gnt      = 1'b0;
        m0_hrd      = 1'b0;
        m1_gnt      = 1'b0;
        m1_hrd      = 1'b0;
        m0_ready    = 1'b1;
        m1_ready    = 1'b1;
        m0_spo      = '0;
        m1_spo      = '0;
        s_req       = 1'b0;
        s_a         = '0;
        s_d         = '0;
        s_we        = 1'b0;
        s_rd        = 1'b0;
        err_timeout = 1'b0;
        err_master  = 1'b0;

        case (state)
            IDLE: begin
                // On a tie the master that did not own the bus last wins.
                if (m0_req && (!m1_req || last)) begin
                    state_nxt = OWN0;
                end else if (m1_req) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                active = 1'b1;
                sel    = 1'b0;
            end
            OWN1: begin
                active = 1'b1;
                sel    = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase

        if (active) begin
            o_req = sel ? m1_req : m0_req;
            o_a   = sel ? m1_a   : m0_a;
            o_d   = sel ? m1_d   : m0_d;
            o_we  = sel ? m1_we  : m0_we;
            o_rd  = sel ? m1_rd  : m0_rd;

            s_req  = o_req & ~s_hrd;
            s_a    = o_a;
            s_d    = o_d;
            s_we   = o_we & s_gnt & ~s_hrd;
            s_rd   = o_rd & s_gnt & ~s_hrd;
            strobe = s_we | s_rd;

            // A new strobe beats a same-cycle s_ready: it opens a fresh access.
            if (strobe) begin
                pending_nxt = 1'b1;
                cnt_nxt     = '0;
            end else if (pending && s_ready) begin
                pending_nxt = 1'b0;
            end else if (pending) begin
                if (cnt == CNT_HIT) begin
                    timeout_hit = 1'b1;
                    pending_nxt = 1'b0;
                end
                if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            o_rdy       = timeout_hit | s_ready;
            o_spo       = timeout_hit ? 32'h0 : s_spo;
            err_timeout = timeout_hit;
            err_master  = timeout_hit & sel;

            // Release only once nothing is outstanding; IDLE always lasts a cycle.
            if (timeout_hit || (!o_req && !pending_nxt)) begin
                state_nxt = IDLE;
                last_nxt  = sel;
            end

            if (sel) begin
                m1_gnt   = 1'b1;
                m0_hrd   = 1'b1;
                m1_ready = o_rdy;
                m1_spo   = o_spo;
                m0_ready = 1'b0;
            end else begin
                m0_gnt   = 1'b1;
                m1_hrd   = 1'b1;
                m0_ready = o_rdy;
                m0_spo   = o_spo;
                m1_ready = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter (TIMEOUT reduced to 8).
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

    localparam int TIMEOUT = 8;
    localparam int TCW     = $clog2(TIMEOUT) + 1;

    // {m0_gnt,m1_gnt,m0_hrd,m1_hrd,m0_ready,m1_ready,s_req,s_we,s_rd}
    localparam logic [8:0] CTL_IDLE = 9'b000011000;
    localparam logic [8:0] CTL_OWN0 = 9'b100100100;
    localparam logic [8:0] CTL_OWN1 = 9'b011000100;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_gnt, m0_hrd, m0_we, m0_rd, m0_ready;
    logic [31:0] m0_a, m0_d, m0_spo;
    logic        m1_req, m1_gnt, m1_hrd, m1_we, m1_rd, m1_ready;
    logic [31:0] m1_a, m1_d, m1_spo;
    logic        s_req, s_gnt, s_hrd, s_we, s_rd, s_ready;
    logic [31:0] s_a, s_d, s_spo;
    logic        err_timeout, err_master;
    logic [1:0]  dbg_state;
    logic [8:0]  ctl;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    // slave model: answers a passed strobe slave_lat cycles later (0 = never)
    int          slave_lat  = 0;
    logic [31:0] slave_data = 32'h0;
    int          slv_cnt    = 0;
    logic [31:0] arm_data   = 32'h0;
    logic [31:0] slv_data_q = 32'h0;
    logic        slv_ready  = 1'b0;
    logic        man_ready  = 1'b0;
    logic [31:0] man_spo    = 32'h0;

    assign s_ready = slv_ready | man_ready;
    assign s_spo   = slv_ready ? slv_data_q : man_spo;
    assign ctl     = {m0_gnt, m1_gnt, m0_hrd, m1_hrd, m0_ready, m1_ready, s_req, s_we, s_rd};

    mem_bus_arbiter #(.TIMEOUT(TIMEOUT), .TCW(TCW)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_hrd(m0_hrd), .m0_a(m0_a), .m0_d(m0_d),
        .m0_we(m0_we), .m0_rd(m0_rd), .m0_spo(m0_spo), .m0_ready(m0_ready),
        .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_hrd(m1_hrd), .m1_a(m1_a), .m1_d(m1_d),
        .m1_we(m1_we), .m1_rd(m1_rd), .m1_spo(m1_spo), .m1_ready(m1_ready),
        .s_req(s_req), .s_gnt(s_gnt), .s_hrd(s_hrd), .s_a(s_a), .s_d(s_d),
        .s_we(s_we), .s_rd(s_rd), .s_spo(s_spo), .s_ready(s_ready),
        .err_timeout(err_timeout), .err_master(err_master), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // slave: arm on a passed strobe (sampled mid-cycle)
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                slv_cnt = 0;
            end else if ((s_rd || s_we) && slave_lat > 0) begin
                slv_cnt  = slave_lat;
                arm_data = slave_data;
            end
        end
    end

    // slave: raise s_ready for one cycle when the latency runs out
    initial begin
        forever begin
            @(posedge clk);
            #1;
            slv_ready = 1'b0;
            if (slv_cnt > 0) begin
                slv_cnt = slv_cnt - 1;
                if (slv_cnt == 0) begin
                    slv_ready  = 1'b1;
                    slv_data_q = arm_data;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_req(input int m, input logic v);
        if (m == 0) m0_req = v; else m1_req = v;
    endtask

    task automatic set_rd(input int m, input logic v);
        if (m == 0) m0_rd = v; else m1_rd = v;
    endtask

    task automatic set_addr(input int m, input logic [31:0] a, input logic [31:0] d);
        if (m == 0) begin m0_a = a; m0_d = d; end
        else begin m1_a = a; m1_d = d; end
    endtask

    task automatic clear_strobes();
        m0_we = 1'b0; m0_rd = 1'b0; m1_we = 1'b0; m1_rd = 1'b0;
    endtask

    function automatic logic gnt_of(input int m);
        return (m == 0) ? m0_gnt : m1_gnt;
    endfunction

    function automatic logic ready_of(input int m);
        return (m == 0) ? m0_ready : m1_ready;
    endfunction

    function automatic logic [31:0] spo_of(input int m);
        return (m == 0) ? m0_spo : m1_spo;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        m0_req = 1'b0; m1_req = 1'b0;
        clear_strobes();
        m0_a = 32'h0; m0_d = 32'h0; m1_a = 32'h0; m1_d = 32'h0;
        s_gnt = 1'b1; s_hrd = 1'b0;
        man_ready = 1'b0; man_spo = 32'h0;
        slave_lat = 0; slave_data = 32'h0;
        exp_q.delete();
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    // Waits for the slave response to master m, checking ownership is held
    // meanwhile, then pops the scoreboard and compares the routed data.
    task automatic wait_resp(input int m, input bit drop, output int lat);
        logic [31:0] e;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            next_cycle();
            clear_strobes();
            if (drop && i == 1) set_req(m, 1'b0);
            mid();
            checks++;
            if (s_ready) begin
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL resp_m%0d: response with empty expected queue", m);
                end else begin
                    e = exp_q.pop_front();
                    if (ready_of(m) !== 1'b1 || ready_of(1 - m) !== 1'b0 || spo_of(m) !== e) begin
                        failures++;
                        $display("FAIL resp_m%0d: ready=%b other_ready=%b spo=%h, expected ready=1 other_ready=0 spo=%h",
                                 m, ready_of(m), ready_of(1 - m), spo_of(m), e);
                    end
                end
                lat = i;
                return;
            end else if (gnt_of(m) !== 1'b1 || ready_of(m) !== 1'b0) begin
                failures++;
                $display("FAIL wait_hold_m%0d: gnt=%b ready=%b, expected gnt=1 ready=0 (cycle %0d)",
                         m, gnt_of(m), ready_of(m), i);
            end
        end
        checks++;
        failures++;
        $display("FAIL resp_m%0d: no slave response within 20 cycles", m);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        m0_a = 32'h1234_5678; m0_d = 32'h9ABC_DEF0; man_spo = 32'hCAFE_0000;
        mid();
        checks++;
        if (ctl !== CTL_IDLE) begin
            failures++; $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_IDLE);
        end
        checks++;
        if (s_a !== 32'h0 || s_d !== 32'h0) begin
            failures++; $display("FAIL reset_sbus: s_a=%h s_d=%h expected 0", s_a, s_d);
        end
        checks++;
        if (m0_spo !== 32'h0 || m1_spo !== 32'h0) begin
            failures++; $display("FAIL reset_spo: m0=%h m1=%h expected 0", m0_spo, m1_spo);
        end
        checks++;
        if (err_timeout !== 1'b0 || err_master !== 1'b0) begin
            failures++; $display("FAIL reset_err: %b%b expected 00", err_timeout, err_master);
        end
        checks++;
        if (dbg_state !== 2'b00) begin
            failures++; $display("FAIL reset_state: got %b expected 00", dbg_state);
        end
    endtask

    task automatic test_single_read();
        int lat;
        do_reset();
        m1_req = 1'b1;
        mid();
        checks++;
        if (ctl !== CTL_IDLE) begin
            failures++; $display("FAIL single_req_cycle: got %b expected %b", ctl, CTL_IDLE);
        end
        next_cycle();
        mid();
        checks++;
        if (ctl !== CTL_OWN1) begin
            failures++; $display("FAIL single_grant: got %b expected %b", ctl, CTL_OWN1);
        end
        next_cycle();
        m1_rd = 1'b1; m1_a = 32'h8000_0010;
        slave_lat = 3; slave_data = 32'hDEAD_BEEF;
        exp_q.push_back(32'hDEAD_BEEF);
        mid();
        checks++;
        if (s_rd !== 1'b1 || s_a !== 32'h8000_0010) begin
            failures++; $display("FAIL single_strobe: s_rd=%b s_a=%h expected 1 80000010", s_rd, s_a);
        end
        wait_resp(1, 1'b0, lat);
        checks++;
        if (lat !== 3) begin
            failures++; $display("FAIL single_latency: got %0d expected 3", lat);
        end
        next_cycle();
        m1_req = 1'b0;
        mid();
        checks++;
        if (m1_gnt !== 1'b1) begin
            failures++; $display("FAIL single_drop_cycle: m1_gnt=%b expected 1", m1_gnt);
        end
        next_cycle();
        mid();
        checks++;
        if (ctl !== CTL_IDLE) begin
            failures++; $display("FAIL single_release: got %b expected %b", ctl, CTL_IDLE);
        end
    endtask

    task automatic test_round_robin();
        int own;
        do_reset();
        m0_req = 1'b1; m1_req = 1'b1;
        mid();
        for (int k = 0; k < 4; k++) begin
            own = k % 2;
            next_cycle();
            mid();
            checks++;
            if (ctl !== ((own == 0) ? CTL_OWN0 : CTL_OWN1)) begin
                failures++; $display("FAIL rr_grant_%0d: got %b expected owner %0d", k, ctl, own);
            end
            next_cycle();
            set_req(own, 1'b0);
            mid();
            checks++;
            if (gnt_of(own) !== 1'b1) begin
                failures++; $display("FAIL rr_drop_%0d: gnt=%b expected 1", k, gnt_of(own));
            end
            next_cycle();
            set_req(own, 1'b1);
            mid();
            checks++;
            if (ctl !== CTL_IDLE) begin
                failures++; $display("FAIL rr_bubble_%0d: got %b expected %b", k, ctl, CTL_IDLE);
            end
        end
    endtask

    task automatic test_drop_pending();
        int lat;
        do_reset();
        m0_req = 1'b1;
        next_cycle();
        m0_we = 1'b1; m0_a = 32'h0000_1000; m0_d = 32'h1122_3344; m1_req = 1'b1;
        slave_lat = 5; slave_data = 32'h5A5A_0001;
        exp_q.push_back(32'h5A5A_0001);
        mid();
        checks++;
        if (s_we !== 1'b1 || s_a !== 32'h0000_1000 || s_d !== 32'h1122_3344) begin
            failures++; $display("FAIL drop_strobe: s_we=%b s_a=%h s_d=%h", s_we, s_a, s_d);
        end
        wait_resp(0, 1'b1, lat);
        checks++;
        if (lat !== 5) begin
            failures++; $display("FAIL drop_latency: got %0d expected 5", lat);
        end
        next_cycle();
        mid();
        checks++;
        if (ctl !== CTL_IDLE) begin
            failures++; $display("FAIL drop_release: got %b expected %b", ctl, CTL_IDLE);
        end
        next_cycle();
        mid();
        checks++;
        if (ctl !== CTL_OWN1) begin
            failures++; $display("FAIL drop_handover: got %b expected %b", ctl, CTL_OWN1);
        end
    endtask

    task automatic test_masking();
        int lat;
        do_reset();
        m0_req = 1'b1;
        next_cycle();
        m1_req = 1'b1; m1_we = 1'b1; m1_a = 32'hBAD0_0000; m1_d = 32'hBAD0_0001;
        m0_a = 32'h0000_2000;
        mid();
        checks++;
        if (s_we !== 1'b0 || s_a !== 32'h0000_2000 || m1_ready !== 1'b0 || m1_hrd !== 1'b1) begin
            failures++; $display("FAIL mask_we: s_we=%b s_a=%h m1_ready=%b m1_hrd=%b", s_we, s_a, m1_ready, m1_hrd);
        end
        next_cycle();
        m1_we = 1'b0; m1_rd = 1'b1; m0_rd = 1'b1;
        slave_lat = 2; slave_data = 32'h1357_9BDF;
        exp_q.push_back(32'h1357_9BDF);
        mid();
        checks++;
        if (s_rd !== 1'b1 || s_we !== 1'b0 || s_a !== 32'h0000_2000) begin
            failures++; $display("FAIL mask_owner_rd: s_rd=%b s_we=%b s_a=%h", s_rd, s_we, s_a);
        end
        wait_resp(0, 1'b0, lat);
        checks++;
        if (lat !== 2) begin
            failures++; $display("FAIL mask_latency: got %0d expected 2", lat);
        end
        // stray s_ready with nothing pending
        next_cycle();
        man_ready = 1'b1; man_spo = 32'h7777_0000;
        mid();
        checks++;
        if (m0_ready !== 1'b1 || m0_spo !== 32'h7777_0000 || m1_ready !== 1'b0 || m1_spo !== 32'h0) begin
            failures++; $display("FAIL stray_ready: m0 %b/%h m1 %b/%h", m0_ready, m0_spo, m1_ready, m1_spo);
        end
        next_cycle();
        man_ready = 1'b0;
        mid();
        checks++;
        if (ctl !== CTL_OWN0) begin
            failures++; $display("FAIL stray_nochange: got %b expected %b", ctl, CTL_OWN0);
        end
        // upstream hold and missing slave grant block strobes
        next_cycle();
        s_hrd = 1'b1; m0_we = 1'b1;
        mid();
        checks++;
        if (s_we !== 1'b0 || s_req !== 1'b0) begin
            failures++; $display("FAIL hold_mask: s_we=%b s_req=%b expected 0 0", s_we, s_req);
        end
        next_cycle();
        s_hrd = 1'b0; m0_we = 1'b0; s_gnt = 1'b0; m0_rd = 1'b1;
        mid();
        checks++;
        if (s_rd !== 1'b0 || s_req !== 1'b1) begin
            failures++; $display("FAIL sgnt_mask: s_rd=%b s_req=%b expected 0 1", s_rd, s_req);
        end
        next_cycle();
        clear_strobes(); s_gnt = 1'b1; m0_req = 1'b0;
        mid();
        next_cycle();
        mid();
        checks++;
        if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
            failures++; $display("FAIL mask_release: m0_gnt=%b m1_gnt=%b expected 0 0", m0_gnt, m1_gnt);
        end
    endtask

    task automatic test_timeout(input int m);
        do_reset();
        set_req(m, 1'b1);
        next_cycle();
        set_rd(m, 1'b1); set_addr(m, 32'h0000_4000 + 32'(m), 32'h0);
        slave_lat = 0; man_spo = 32'hFEED_FACE;
        mid();
        checks++;
        if (s_rd !== 1'b1) begin
            failures++; $display("FAIL to_strobe_m%0d: s_rd=%b expected 1", m, s_rd);
        end
        for (int i = 1; i <= 8; i++) begin
            next_cycle();
            clear_strobes();
            mid();
            checks++;
            if (i < 7) begin
                if (err_timeout !== 1'b0 || gnt_of(m) !== 1'b1 || ready_of(m) !== 1'b0) begin
                    failures++; $display("FAIL to_wait_m%0d_%0d: err=%b gnt=%b ready=%b expected 0 1 0",
                                         m, i, err_timeout, gnt_of(m), ready_of(m));
                end
            end else if (i == 7) begin
                if (err_timeout !== 1'b1 || err_master !== (m == 1) || ready_of(m) !== 1'b1 || spo_of(m) !== 32'h0) begin
                    failures++; $display("FAIL to_abort_m%0d: err=%b master=%b ready=%b spo=%h expected 1 %0d 1 0",
                                         m, err_timeout, err_master, ready_of(m), spo_of(m), m);
                end
            end else begin
                if (err_timeout !== 1'b0 || ctl !== CTL_IDLE) begin
                    failures++; $display("FAIL to_idle_m%0d: err=%b ctl=%b expected 0 %b", m, err_timeout, ctl, CTL_IDLE);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] e;
        do_reset();
        m0_req = 1'b1;
        next_cycle();
        m0_rd = 1'b1; m0_a = 32'h0000_3000;
        slave_lat = 2; slave_data = 32'hAAAA_0001;
        exp_q.push_back(32'hAAAA_0001);
        mid();
        next_cycle();
        m0_rd = 1'b0;
        mid();
        next_cycle();
        m0_rd = 1'b1; m0_a = 32'h0000_3004; slave_data = 32'hAAAA_0002;
        exp_q.push_back(32'hAAAA_0002);
        mid();
        e = exp_q.pop_front();
        checks++;
        if (s_ready !== 1'b1 || m0_ready !== 1'b1 || m0_spo !== e || s_rd !== 1'b1) begin
            failures++; $display("FAIL b2b_first: s_ready=%b m0_ready=%b m0_spo=%h s_rd=%b expected 1 1 %h 1",
                                 s_ready, m0_ready, m0_spo, s_rd, e);
        end
        wait_resp(0, 1'b1, lat);
        checks++;
        if (lat !== 2) begin
            failures++; $display("FAIL b2b_latency: got %0d expected 2", lat);
        end
        next_cycle();
        mid();
        checks++;
        if (ctl !== CTL_IDLE) begin
            failures++; $display("FAIL b2b_release: got %b expected %b", ctl, CTL_IDLE);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        m1_req = 1'b1;
        next_cycle();
        m1_rd = 1'b1; slave_lat = 0;
        mid();
        next_cycle();
        m1_rd = 1'b0; rst = 1'b1;
        mid();
        next_cycle();
        rst = 1'b0; m1_req = 1'b0;
        mid();
        checks++;
        if (ctl !== CTL_IDLE || dbg_state !== 2'b00) begin
            failures++; $display("FAIL rstmid_idle: ctl=%b state=%b expected %b 00", ctl, dbg_state, CTL_IDLE);
        end
        next_cycle();
        man_ready = 1'b1; man_spo = 32'h0BAD_0BAD;
        mid();
        checks++;
        if (ctl !== CTL_IDLE || m0_spo !== 32'h0 || m1_spo !== 32'h0) begin
            failures++; $display("FAIL rstmid_late_ready: ctl=%b m0_spo=%h m1_spo=%h", ctl, m0_spo, m1_spo);
        end
        next_cycle();
        man_ready = 1'b0; m0_req = 1'b1;
        mid();
        checks++;
        if (ctl !== CTL_IDLE) begin
            failures++; $display("FAIL rstmid_still_idle: got %b expected %b", ctl, CTL_IDLE);
        end
        next_cycle();
        m0_req = 1'b0;
        mid();
        checks++;
        if (m0_gnt !== 1'b1) begin
            failures++; $display("FAIL rstmid_regrant: m0_gnt=%b expected 1", m0_gnt);
        end
        next_cycle();
        mid();
        checks++;
        if (m0_gnt !== 1'b0) begin
            failures++; $display("FAIL rstmid_no_pending: m0_gnt=%b expected 0", m0_gnt);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_drop_pending();
        test_masking();
        test_timeout(0);
        test_timeout(1);
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Two-master, one-slave arbiter for the physical memory bus (req/gnt/hrd, a/d/we/rd, spo/ready protocol). Master 0 is the instruction-side MMU; master 1 is the data-side MMU. Each MMU sees the arbiter as its physical bus. The arbiter grants ownership round-robin, holds it across outstanding accesses, and aborts accesses the slave never completes.

Parameters:
TIMEOUT, 1024, cycles an outstanding access may wait for s_ready before abort (>=2)
TCW, 11, timeout counter width, $clog2(TIMEOUT)+1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
m0_req  in  1  master 0 requests bus
m0_gnt  out  1  master 0 owns bus
m0_hrd  out  1  bus held by master 1; master 0 must not strobe
m0_a  in  32  address
m0_d  in  32  write data
m0_we  in  1  write strobe (one cycle per access)
m0_rd  in  1  read strobe (one cycle per access)
m0_spo  out  32  read data
m0_ready  out  1  access complete / bus idle
m1_*  same set as m0_* for master 1
s_req  out  1  request to slave side
s_gnt  in  1  slave-side grant
s_hrd  in  1  slave-side hold (from upstream arbiter)
s_a, s_d  out  32  muxed address / data
s_we, s_rd  out  1  muxed strobes
s_spo  in  32  slave read data
s_ready  in  1  slave ready
err_timeout  out  1  one-cycle pulse on abort
err_master  out  1  owner at abort, valid with err_timeout

Behaviour:
- Clock is clk; reset is synchronous, active-high, on rst. Reset: state IDLE, last=1 (master 0 wins first tie), pending=0, counter=0. All gnt/hrd/err outputs 0. m*_ready=1. s_req/s_we/s_rd=0. s_a/s_d=0.
- States: IDLE, OWN0, OWN1.
- IDLE: only m0_req -> OWN0; only m1_req -> OWN1. Both -> master != last. Transition is registered, so gnt rises the cycle after req. No strobes pass in IDLE.
- OWNn: mn_gnt=1; the other master's hrd=1 and gnt=0. s_req = mn_req & !s_hrd. s_a/s_d = mn_a/mn_d. s_we = mn_we & s_gnt & !s_hrd; s_rd likewise. Non-owner strobes are masked and produce no access.
- pending: set on a strobe that passed (s_we|s_rd). Cleared on s_ready while pending. A strobe and s_ready in the same cycle: the strobe wins (pending stays 1); it is a new access.
- Release: the owner leaves OWNn for IDLE when mn_req=0 and pending=0, or on timeout abort. last<=n on release. No same-cycle re-grant; IDLE lasts at least one cycle (bus-switch bubble). If the owner drops req while pending, ownership holds until s_ready.
- Ready/data routing: the owner gets mn_ready = s_ready and mn_spo = s_spo. The non-owner gets mn_ready=0 and mn_spo=0. In IDLE, both m*_ready=1 and both spo=0.
- Timeout: counter resets to 0 on each passed strobe and increments while pending & !s_ready. When it reaches TIMEOUT-1 with pending still set: err_timeout=1 for one cycle, err_master=n, pending<=0, owner mn_ready=1 that cycle, spo=0, state<=IDLE. The counter saturates and never wraps.
- s_ready arriving with no access pending passes only to the owner and changes no state.
- Reset mid-access: everything returns to reset values next cycle. No partial access is replayed.
- Any unused state encoding -> IDLE next cycle.

Test Plan:
- Single master: m1_req=1 at cycle 0 -> m1_gnt=1 at cycle 1, m0_hrd=1. m1_rd strobe with a=0x8000_0010, slave ready 3 cycles later with spo=0xDEADBEEF -> m1_spo=0xDEADBEEF, m1_ready=1 on that cycle.
- Tie after reset: m0_req=m1_req=1 at cycle 0 -> OWN0 at cycle 1. m0 drops req -> IDLE for one cycle, then OWN1. Repeat -> alternates 0,1,0,1.
- Drop with pending: owner strobes m0_we, deasserts m0_req next cycle, s_ready 5 cycles later -> m0_gnt stays 1 until s_ready, then IDLE. m1 is granted 2 cycles after s_ready.
- Masking: m1_we pulses while OWN0 -> s_we stays 0 and m1_ready=0. The slave sees only m0 traffic on s_a.
- Timeout with TIMEOUT=8: strobe with s_ready held 0 -> err_timeout pulses exactly 7 cycles after the strobe, err_master=owner, owner ready=1, state IDLE next cycle.
- Reset during pending read: rst=1 for one cycle -> next cycle both gnt=0, s_rd=0, m*_ready=1, pending cleared. A late s_ready after reset causes no state change.
